// File: rtl/q_load_ctrl_pkg.sv
// rtl/q_load_ctrl_pkg.sv - shared types and sizes for the Q row loader
package q_load_ctrl_pkg;

    // Number of processing elements; one Q row per PE fills a bank.
    localparam int NUM_PES    = 4;
    localparam int Q_ELEM_W   = 16;
    localparam int Q_VECTOR_W = NUM_PES * Q_ELEM_W;

    typedef logic [Q_VECTOR_W-1:0] q_vector_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } q_load_state_t;

endpackage

// File: rtl/q_load_ctrl.sv
// rtl/q_load_ctrl.sv - streams Q rows from memory into the Q buffer fill bank
module q_load_ctrl
    import q_load_ctrl_pkg::*;
#(
    parameter int NUM_ROWS  = NUM_PES,
    parameter int ADDR_W    = 32,
    parameter int ROW_BYTES = 64,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_rows,
    output logic              busy,
    output logic              done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  q_vector_t         mem_resp_data,
    output logic              sram_write_enable,
    output q_vector_t         sram_write_data,
    input  logic              sram_ready
);

    localparam int OUT_W  = $clog2(MAX_OUTST + 1);
    localparam int BANK_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    q_load_state_t     state;
    q_load_state_t     state_next;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  written;
    logic [OUT_W-1:0]  outstanding;
    logic [BANK_W-1:0] bank_idx;
    logic [BANK_W-1:0] bank_next;

    logic can_issue;
    logic req_fire;
    logic resp_fire;
    logic wr_fire;
    logic bank_wrap;
    logic last_write;

    // Request eligibility and handshake decodes, kept outside the FSM block
    // so the next-state logic never feeds back on its own outputs.
    assign can_issue  = (state == LOAD) && (issued < num_q) &&
                        (outstanding < OUT_W'(MAX_OUTST));
    assign req_fire   = can_issue && mem_req_ready;
    assign resp_fire  = (state == LOAD) && mem_resp_valid && sram_ready;
    assign wr_fire    = (((state == LOAD) && mem_resp_valid) || (state == PAD)) && sram_ready;
    assign bank_wrap  = (bank_idx == BANK_W'(NUM_ROWS - 1));
    assign bank_next  = bank_wrap ? '0 : bank_idx + BANK_W'(1);
    assign last_write = ((written + CNT_W'(1)) == num_q);

    assign mem_req_addr = base_q + ADDR_W'(issued) * ADDR_W'(ROW_BYTES);

    // Next-state decode and per-state output drive.
    always_comb begin
        state_next        = state;
        busy              = 1'b0;
        done              = 1'b0;
        mem_req_valid     = 1'b0;
        mem_resp_ready    = 1'b0;
        sram_write_enable = 1'b0;
        sram_write_data   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy              = 1'b1;
                mem_req_valid     = can_issue;
                mem_resp_ready    = sram_ready;
                sram_write_enable = mem_resp_valid;
                sram_write_data   = mem_resp_data;
                if (wr_fire && last_write) begin
                    state_next = bank_wrap ? DONE : PAD;
                end
            end
            PAD: begin
                busy              = 1'b1;
                sram_write_enable = 1'b1;
                if (wr_fire && bank_wrap) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, job latch and progress counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            issued      <= '0;
            written     <= '0;
            outstanding <= '0;
            bank_idx    <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && start) begin
                base_q      <= base_addr;
                num_q       <= num_rows;
                issued      <= '0;
                written     <= '0;
                outstanding <= '0;
                bank_idx    <= '0;
            end else begin
                if (req_fire) begin
                    issued <= issued + CNT_W'(1);
                end
                case ({req_fire, resp_fire})
                    2'b10:   outstanding <= outstanding + OUT_W'(1);
                    2'b01:   outstanding <= outstanding - OUT_W'(1);
                    default: outstanding <= outstanding;
                endcase
                if (wr_fire) begin
                    bank_idx <= bank_next;
                    if (state == LOAD) begin
                        written <= written + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_q_load_ctrl.sv
// tb/tb_q_load_ctrl.sv - self-checking bench for q_load_ctrl
module tb_q_load_ctrl;
    import q_load_ctrl_pkg::*;

    localparam int NR   = 4;
    localparam int MAXO = 4;
    localparam int RB   = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] num_rows = '0;
    logic        busy, done;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic        mem_resp_ready;
    q_vector_t   mem_resp_data = '0;
    logic        sram_write_enable;
    q_vector_t   sram_write_data;
    logic        sram_ready = 1'b1;

    q_load_ctrl #(
        .NUM_ROWS (NR),
        .ADDR_W   (32),
        .ROW_BYTES(RB),
        .MAX_OUTST(MAXO),
        .CNT_W    (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_addr        (base_addr),
        .num_rows         (num_rows),
        .busy             (busy),
        .done             (done),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_ready   (mem_resp_ready),
        .mem_resp_data    (mem_resp_data),
        .sram_write_enable(sram_write_enable),
        .sram_write_data  (sram_write_data),
        .sram_ready       (sram_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic q_vector_t row_data(logic [31:0] addr);
        return {addr, addr ^ 32'hA5A5_5A5A};
    endfunction

    // Job-level model: what the job must produce, derived from base/num only.
    logic [31:0] exp_addr_q[$];
    q_vector_t   exp_wr_q[$];
    logic [31:0] pend[$];
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_num = 0;
    int          m_issued = 0;
    int          m_written = 0;
    int          m_outst = 0;

    int          n_req = 0, n_wr = 0, n_pad = 0, n_done = 0;
    logic [31:0] first_addr = '0, last_addr = '0;

    bit resp_en = 1;
    bit junk_resp = 0;

    // Memory responder: returns rows in request order, one cycle after issue at the earliest.
    always @(posedge clk) begin
        #1;
        if (junk_resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        end else if (!rst) begin
            mem_resp_valid = 1'b0;
        end else if (resp_en && pend.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = row_data(pend[0]);
        end else begin
            mem_resp_valid = 1'b0;
        end
    end

    // Compare process: checks every output against the model each cycle, then advances the model.
    always @(negedge clk) begin
        bit ld, req_hs, resp_hs, wr_hs, nb, nd;
        if (!rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_req_valid", mem_req_valid, 0);
            chk("rst_resp_ready", mem_resp_ready, 0);
            chk("rst_wr_en", sram_write_enable, 0);
            exp_addr_q.delete(); exp_wr_q.delete(); pend.delete();
            m_busy = 0; m_done = 0; m_issued = 0; m_written = 0; m_outst = 0; m_num = 0;
        end else begin
            ld = m_busy && (m_written < m_num);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("req_valid", mem_req_valid, m_busy && m_issued < m_num && m_outst < MAXO);
            chk("resp_ready", mem_resp_ready, ld ? sram_ready : 1'b0);
            chk("wr_en", sram_write_enable, ld ? mem_resp_valid : m_busy);
            req_hs  = mem_req_valid && mem_req_ready;
            resp_hs = mem_resp_valid && mem_resp_ready;
            wr_hs   = sram_write_enable && sram_ready;
            nb = m_busy;
            nd = 1'b0;
            if (done) n_done++;
            if (req_hs) begin
                if (exp_addr_q.size() == 0) begin
                    chk("extra_req", 1, 0);
                end else begin
                    chk("req_addr", mem_req_addr, exp_addr_q.pop_front());
                end
                if (n_req == 0) first_addr = mem_req_addr;
                last_addr = mem_req_addr;
                pend.push_back(mem_req_addr);
                n_req++;
                m_issued++;
                m_outst++;
            end
            if (resp_hs) begin
                if (pend.size() > 0) void'(pend.pop_front());
                m_outst--;
            end
            if (wr_hs && m_busy) begin
                if (exp_wr_q.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    chk("wr_data", sram_write_data, exp_wr_q.pop_front());
                    if (exp_wr_q.size() == 0) begin
                        nb = 0;
                        nd = 1;
                    end
                end
                if (!ld) n_pad++;
                n_wr++;
                m_written++;
            end
            if (!m_busy && !m_done && start) begin
                m_num = num_rows;
                m_issued = 0; m_written = 0; m_outst = 0;
                exp_addr_q.delete(); exp_wr_q.delete();
                for (int i = 0; i < m_num; i++) begin
                    exp_addr_q.push_back(base_addr + 32'(i * RB));
                    exp_wr_q.push_back(row_data(base_addr + 32'(i * RB)));
                end
                while (exp_wr_q.size() % NR != 0) exp_wr_q.push_back('0);
                if (m_num == 0) nd = 1;
                else nb = 1;
            end
            m_busy = nb;
            m_done = nd;
        end
    end

    task automatic clear_counts();
        n_req = 0; n_wr = 0; n_pad = 0; n_done = 0;
        first_addr = '0; last_addr = '0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; num_rows = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(posedge clk); #1;
            if (!m_busy && !m_done) break;
        end
        if (k == bound) begin
            checks++;
            errors++;
            $display("FAIL timeout: job still running after %0d cycles", bound);
        end
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Aligned job: 8 rows, two full banks, no padding.
        clear_counts();
        pulse_start(32'h1000, 16'd8);
        wait_idle(200);
        chk("a_nreq", n_req, 8);
        chk("a_first", first_addr, 32'h1000);
        chk("a_last", last_addr, 32'h11C0);
        chk("a_nwr", n_wr, 8);
        chk("a_npad", n_pad, 0);
        chk("a_ndone", n_done, 1);

        // Unaligned job: 6 rows padded by 2 zero rows.
        clear_counts();
        pulse_start(32'h3000, 16'd6);
        wait_idle(200);
        chk("b_nreq", n_req, 6);
        chk("b_nwr", n_wr, 8);
        chk("b_npad", n_pad, 2);
        chk("b_ndone", n_done, 1);

        // Memory silent: issue stops at the outstanding limit.
        clear_counts();
        resp_en = 0;
        pulse_start(32'h4000, 16'd8);
        repeat (12) @(posedge clk);
        #1;
        chk("c_nreq_limit", n_req, 4);
        chk("c_req_valid_off", mem_req_valid, 0);
        resp_en = 1;
        wait_idle(200);
        chk("c_nwr", n_wr, 8);
        chk("c_ndone", n_done, 1);

        // SRAM stall mid-job.
        clear_counts();
        pulse_start(32'h5000, 16'd12);
        repeat (2) @(posedge clk);
        #1 sram_ready = 1'b0;
        w = n_wr;
        repeat (10) @(posedge clk);
        #1;
        chk("d_nwr_frozen", n_wr, w);
        chk("d_resp_ready_off", mem_resp_ready, 0);
        chk("d_nreq_limit", n_req, w + 4);
        sram_ready = 1'b1;
        wait_idle(300);
        chk("d_nwr", n_wr, 12);
        chk("d_npad", n_pad, 0);
        chk("d_ndone", n_done, 1);

        // Empty job.
        clear_counts();
        pulse_start(32'h6000, 16'd0);
        wait_idle(20);
        chk("e_nreq", n_req, 0);
        chk("e_nwr", n_wr, 0);
        chk("e_ndone", n_done, 1);

        // Start while busy is ignored.
        clear_counts();
        pulse_start(32'h7000, 16'd5);
        repeat (2) @(posedge clk);
        pulse_start(32'h8000, 16'd3);
        wait_idle(200);
        chk("f_nreq", n_req, 5);
        chk("f_first", first_addr, 32'h7000);
        chk("f_nwr", n_wr, 8);
        chk("f_npad", n_pad, 3);
        chk("f_ndone", n_done, 1);

        // Reset mid-LOAD, then a clean job.
        clear_counts();
        pulse_start(32'h9000, 16'd8);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("g_busy", busy, 0);
        chk("g_req_valid", mem_req_valid, 0);
        chk("g_resp_ready", mem_resp_ready, 0);
        chk("g_wr_en", sram_write_enable, 0);
        chk("g_done", done, 0);
        junk_resp = 1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 junk_resp = 0;
        chk("g_no_done", n_done, 0);
        clear_counts();
        pulse_start(32'hA000, 16'd4);
        wait_idle(200);
        chk("h_nreq", n_req, 4);
        chk("h_first", first_addr, 32'hA000);
        chk("h_nwr", n_wr, 4);
        chk("h_ndone", n_done, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
